// File: rtl/dump_pkg.sv
// Shared types and constants for the end-of-program state dump unit.
package dump_pkg;

    typedef enum logic [3:0] {
        RUN,
        HDR,
        RF_REQ,
        RF_CAP,
        RF_SEND,
        DM_REQ,
        DM_CAP,
        DM_SEND,
        DONE
    } state_e;

    localparam logic [31:0] HALT_WORD      = 32'h0;
    localparam int unsigned STATUS_TIMEOUT = 31;

endpackage

// File: rtl/state_dump_unit.sv
// Detects halt/timeout, freezes the core, then streams header + regfile + dmem
// contents as one valid/ready frame.
module state_dump_unit
    import dump_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_MEM  = 32,
    parameter int unsigned TIMEOUT  = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr_in,
    output logic            cpu_freeze,
    output logic [4:0]      rf_rd_addr,
    input  logic [XLEN-1:0] rf_rd_data,
    output logic [4:0]      dm_rd_addr,
    input  logic [XLEN-1:0] dm_rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_last,
    output logic            done
);

    localparam int unsigned AW = 5;

    state_e          state, state_n;
    logic [XLEN-1:0] cnt, cnt_n, cnt_inc;
    logic [AW-1:0]   idx, idx_n;
    logic [AW-1:0]   rf_addr_n, dm_addr_n;
    logic [XLEN-1:0] out_data_n;
    logic            freeze_n, valid_n, last_n, done_n;
    logic            accept;

    assign accept  = out_valid & out_ready;
    assign cnt_inc = cnt + XLEN'(1);

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= '0;
            idx        <= '0;
            rf_rd_addr <= '0;
            dm_rd_addr <= '0;
            out_data   <= '0;
            cpu_freeze <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            rf_rd_addr <= rf_addr_n;
            dm_rd_addr <= dm_addr_n;
            out_data   <= out_data_n;
            cpu_freeze <= freeze_n;
            out_valid  <= valid_n;
            out_last   <= last_n;
            done       <= done_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        rf_addr_n  = rf_rd_addr;
        dm_addr_n  = dm_rd_addr;
        out_data_n = out_data;
        freeze_n   = cpu_freeze;
        valid_n    = out_valid;
        last_n     = out_last;
        done_n     = done;

        case (state)
            RUN: begin
                cnt_n = cnt_inc;
                // Halt has priority: status is 1 only when the word is non-zero
                if (instr_in == XLEN'(HALT_WORD) || cnt_inc == XLEN'(TIMEOUT)) begin
                    state_n    = HDR;
                    freeze_n   = 1'b1;
                    valid_n    = 1'b1;
                    out_data_n = {instr_in != XLEN'(HALT_WORD), cnt_inc[XLEN-2:0]};
                end
            end
            HDR: begin
                if (accept) begin
                    valid_n   = 1'b0;
                    idx_n     = '0;
                    rf_addr_n = '0;
                    state_n   = RF_REQ;
                end
            end
            RF_REQ: state_n = RF_CAP;
            RF_CAP: begin
                out_data_n = rf_rd_data;
                valid_n    = 1'b1;
                state_n    = RF_SEND;
            end
            RF_SEND: begin
                if (accept) begin
                    valid_n = 1'b0;
                    if (idx == AW'(NUM_REGS - 1)) begin
                        idx_n     = '0;
                        dm_addr_n = '0;
                        state_n   = DM_REQ;
                    end else begin
                        idx_n     = idx + AW'(1);
                        rf_addr_n = idx + AW'(1);
                        state_n   = RF_REQ;
                    end
                end
            end
            DM_REQ: state_n = DM_CAP;
            DM_CAP: begin
                out_data_n = dm_rd_data;
                valid_n    = 1'b1;
                last_n     = (idx == AW'(NUM_MEM - 1));
                state_n    = DM_SEND;
            end
            DM_SEND: begin
                if (accept) begin
                    valid_n = 1'b0;
                    if (out_last) begin
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        idx_n     = idx + AW'(1);
                        dm_addr_n = idx + AW'(1);
                        state_n   = DM_REQ;
                    end
                end
            end
            DONE: begin
                done_n   = 1'b1;
                freeze_n = 1'b1;
            end
            default: state_n = RUN;
        endcase
    end

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed bench for state_dump_unit with behavioural 1-cycle-latency RF/dmem.
module tb_state_dump_unit;

    localparam int unsigned NW = 65;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        cpu_freeze;
    logic [4:0]  rf_rd_addr, dm_rd_addr;
    logic [31:0] rf_rd_data, dm_rd_data;
    logic        out_valid, out_ready, out_last, done;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    state_dump_unit dut (
        .clk        (clk),
        .rst        (rst),
        .instr_in   (instr_in),
        .cpu_freeze (cpu_freeze),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .dm_rd_addr (dm_rd_addr),
        .dm_rd_data (dm_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Register file holds r[i]=i, dmem holds mem[i]=i<<4; synchronous reads
    always @(posedge clk) begin
        rf_rd_data <= {27'd0, rf_rd_addr};
        dm_rd_data <= {23'd0, dm_rd_addr, 4'd0};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int i, input logic [31:0] hdr);
        if (i == 0) return hdr;
        if (i <= 32) return 32'(i - 1);
        return 32'(i - 33) << 4;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        instr_in  = NOP;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_freeze"}, {31'd0, cpu_freeze}, 32'd0);
        chk({tag, "_valid"},  {31'd0, out_valid},  32'd0);
        chk({tag, "_last"},   {31'd0, out_last},   32'd0);
        chk({tag, "_done"},   {31'd0, done},       32'd0);
        chk({tag, "_data"},   out_data,            32'd0);
        chk({tag, "_rfaddr"}, {27'd0, rf_rd_addr}, 32'd0);
        chk({tag, "_dmaddr"}, {27'd0, dm_rd_addr}, 32'd0);
    endtask

    // Release reset, present NOPs, then the zero word on the n-th run edge
    task automatic run_to_halt(input int n);
        rst = 1'b0;
        for (int k = 1; k <= n; k++) begin
            instr_in = (k == n) ? 32'd0 : NOP;
            @(negedge clk);
            if (k == n - 1) chk("pre_halt_freeze", {31'd0, cpu_freeze}, 32'd0);
        end
        instr_in = NOP;
        chk("detect_freeze", {31'd0, cpu_freeze}, 32'd1);
        chk("detect_valid",  {31'd0, out_valid},  32'd1);
    endtask

    // mode 0: ready=1, mode 1: random ready, mode 2: ready=0 for first 50 cycles
    task automatic recv(input int mode, input int nwords, input logic [31:0] hdr);
        int          got = 0;
        int          cyc = 0;
        logic        stall = 1'b0;
        logic [31:0] held = '0;
        logic        held_last = 1'b0;
        logic        rdy;
        while (got < nwords && cyc < 3000) begin
            chk("dump_freeze", {31'd0, cpu_freeze}, 32'd1);
            if (stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data",  out_data, held);
                chk("stall_last",  {31'd0, out_last}, {31'd0, held_last});
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else                rdy = (cyc >= 50);
            out_ready = rdy;
            if (out_valid && rdy) begin
                chk($sformatf("word%0d", got), out_data, exp_word(got, hdr));
                chk($sformatf("last%0d", got), {31'd0, out_last}, {31'd0, got == NW - 1});
                got++;
                stall = 1'b0;
            end else if (out_valid) begin
                stall     = 1'b1;
                held      = out_data;
                held_last = out_last;
            end else begin
                stall = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("recv_budget", 32'(got), 32'(nwords));
        out_ready = 1'b0;
    endtask

    task automatic check_done();
        instr_in = 32'd0;
        repeat (3) @(negedge clk);
        chk("done_flag",   {31'd0, done},       32'd1);
        chk("done_valid",  {31'd0, out_valid},  32'd0);
        chk("done_freeze", {31'd0, cpu_freeze}, 32'd1);
        chk("done_last",   {31'd0, out_last},   32'd0);
        instr_in = NOP;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        instr_in  = NOP;
        out_ready = 1'b0;

        // Reset state
        do_reset();
        check_zero("reset");

        // Halt at cycle 12, ready always high
        run_to_halt(12);
        chk("hdr_halt12", out_data, 32'h0000_000C);
        recv(0, NW, 32'h0000_000C);
        chk("done_after_frame", {31'd0, done}, 32'd1);
        check_done();

        // No halt: forced dump at timeout
        do_reset();
        rst = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd100);
        chk("hdr_timeout", out_data, 32'h8000_0064);
        recv(0, NW, 32'h8000_0064);
        check_done();

        // Halt coincident with timeout: halt wins
        do_reset();
        run_to_halt(100);
        chk("hdr_tie", out_data, 32'h0000_0064);
        recv(0, NW, 32'h0000_0064);
        check_done();

        // Random backpressure
        do_reset();
        run_to_halt(7);
        recv(1, NW, 32'h0000_0007);
        check_done();

        // Header stalled for 50 cycles
        do_reset();
        run_to_halt(3);
        recv(2, NW, 32'h0000_0003);
        check_done();

        // Reset mid-dump after 20 words, then a clean rerun
        do_reset();
        run_to_halt(9);
        recv(0, 20, 32'h0000_0009);
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        run_to_halt(5);
        chk("hdr_rerun", out_data, 32'h0000_0005);
        recv(1, NW, 32'h0000_0005);
        check_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
